// File: rtl/serial_adder_nbit_if.sv
// Handshake and operand/result bundle for serial_adder_nbit.
// The master drives a request and the slave (the adder) returns status and the result.
interface serial_adder_nbit_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder: computes a+b+cin CHUNK bits per clock through one ripple slice,
// LSB chunk first, with a start/busy/done handshake.
module serial_adder_nbit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_nbit_if.slave bus
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("serial_adder_nbit: CHUNK must be >= 1 and divide WIDTH exactly");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        base;
  logic               accept;
  logic               last;
  logic [CHUNK+1:0]   slice;

  // Ripple chain of full-adder cells; returns {carry into top bit, carry out, sum bits}.
  function automatic logic [CHUNK+1:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] s;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[CHUNK-1], c[CHUNK], s};
  endfunction

  assign base   = 32'(cnt) * CHUNK;
  assign accept = bus.start && (state == IDLE || state == DONE);
  assign last   = (cnt == CNT_W'(STEPS - 1));
  assign slice  = add_chunk(a_q[base +: CHUNK], b_q[base +: CHUNK], carry_q);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        carry_q <= bus.cin;
        cnt     <= '0;
      end else if (state == RUN) begin
        sum_q[base +: CHUNK] <= slice[CHUNK-1:0];
        carry_q              <= slice[CHUNK];
        cnt                  <= cnt + CNT_W'(1);
        if (last) begin
          cout_q <= slice[CHUNK];
          ovf_q  <= slice[CHUNK+1] ^ slice[CHUNK];
        end
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed bench for serial_adder_nbit across four WIDTH/CHUNK configurations sharing one clock and reset.
module tb_serial_adder_nbit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_adder_nbit_if #(.WIDTH(1))  bus_w1c1  ();
  serial_adder_nbit_if #(.WIDTH(8))  bus_w8c1  ();
  serial_adder_nbit_if #(.WIDTH(8))  bus_w8c4  ();
  serial_adder_nbit_if #(.WIDTH(16)) bus_w16c2 ();

  serial_adder_nbit #(.WIDTH(1),  .CHUNK(1)) u_w1c1  (.clk(clk), .rst_n(rst_n), .bus(bus_w1c1));
  serial_adder_nbit #(.WIDTH(8),  .CHUNK(1)) u_w8c1  (.clk(clk), .rst_n(rst_n), .bus(bus_w8c1));
  serial_adder_nbit #(.WIDTH(8),  .CHUNK(4)) u_w8c4  (.clk(clk), .rst_n(rst_n), .bus(bus_w8c4));
  serial_adder_nbit #(.WIDTH(16), .CHUNK(2)) u_w16c2 (.clk(clk), .rst_n(rst_n), .bus(bus_w16c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic st, input logic [15:0] av,
                       input logic [15:0] bv, input logic ci);
    case (k)
      0: begin bus_w1c1.start = st;  bus_w1c1.a = av[0];       bus_w1c1.b = bv[0];       bus_w1c1.cin = ci;  end
      1: begin bus_w8c1.start = st;  bus_w8c1.a = av[7:0];     bus_w8c1.b = bv[7:0];     bus_w8c1.cin = ci;  end
      2: begin bus_w8c4.start = st;  bus_w8c4.a = av[7:0];     bus_w8c4.b = bv[7:0];     bus_w8c4.cin = ci;  end
      default: begin bus_w16c2.start = st; bus_w16c2.a = av;   bus_w16c2.b = bv;         bus_w16c2.cin = ci; end
    endcase
  endtask

  function automatic logic get_done(input int k);
    case (k)
      0: return bus_w1c1.done;
      1: return bus_w8c1.done;
      2: return bus_w8c4.done;
      default: return bus_w16c2.done;
    endcase
  endfunction

  function automatic logic get_busy(input int k);
    case (k)
      0: return bus_w1c1.busy;
      1: return bus_w8c1.busy;
      2: return bus_w8c4.busy;
      default: return bus_w16c2.busy;
    endcase
  endfunction

  function automatic logic [15:0] get_sum(input int k);
    case (k)
      0: return {15'd0, bus_w1c1.sum};
      1: return {8'd0, bus_w8c1.sum};
      2: return {8'd0, bus_w8c4.sum};
      default: return bus_w16c2.sum;
    endcase
  endfunction

  function automatic logic get_cout(input int k);
    case (k)
      0: return bus_w1c1.cout;
      1: return bus_w8c1.cout;
      2: return bus_w8c4.cout;
      default: return bus_w16c2.cout;
    endcase
  endfunction

  function automatic logic get_ovf(input int k);
    case (k)
      0: return bus_w1c1.overflow;
      1: return bus_w8c1.overflow;
      2: return bus_w8c4.overflow;
      default: return bus_w16c2.overflow;
    endcase
  endfunction

  // One transaction; operands are scrambled right after acceptance. Latency counts the accepting edge.
  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        output logic [15:0] s, output logic co, output logic ov,
                        output int lat, output int busy_cyc, output logic dn_next);
    @(negedge clk);
    drive(k, 1'b1, av, bv, ci);
    @(negedge clk);
    drive(k, 1'b0, ~av, ~bv, ~ci);
    lat = 1;
    busy_cyc = 0;
    while (!get_done(k) && lat < 64) begin
      if (get_busy(k)) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    s  = get_sum(k);
    co = get_cout(k);
    ov = get_ovf(k);
    @(negedge clk);
    dn_next = get_done(k);
  endtask

  task automatic do_check(input int k, input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic [15:0] exp_s, input logic exp_co,
                          input logic exp_ov, input int exp_lat);
    logic [15:0] s;
    logic        co, ov, dn_next;
    int          lat, busy_cyc;
    run_op(k, av, bv, ci, s, co, ov, lat, busy_cyc, dn_next);
    check_eq({tag, " sum"},      32'(s),        32'(exp_s));
    check_eq({tag, " cout"},     32'(co),       32'(exp_co));
    check_eq({tag, " overflow"}, 32'(ov),       32'(exp_ov));
    check_eq({tag, " latency"},  32'(lat),      32'(exp_lat));
    check_eq({tag, " busy_cyc"}, 32'(busy_cyc), 32'(exp_lat - 1));
    check_eq({tag, " done_one"}, 32'(dn_next),  32'(0));
  endtask

  logic [7:0]  sum_tab  = 8'b10010110;
  logic [7:0]  cout_tab = 8'b11101000;
  logic [7:0]  ovf_tab  = 8'b01000010;

  initial begin
    logic [2:0]  iv;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] full;
    int          lat2;
    int          done_seen;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 16'h0, 16'h0, 1'b0);

    #23;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("reset busy %0d", k), 32'(get_busy(k)), 32'(0));
      check_eq($sformatf("reset done %0d", k), 32'(get_done(k)), 32'(0));
      check_eq($sformatf("reset sum %0d", k),  32'(get_sum(k)),  32'(0));
      check_eq($sformatf("reset cout %0d", k), 32'(get_cout(k)), 32'(0));
      check_eq($sformatf("reset ovf %0d", k),  32'(get_ovf(k)),  32'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Registered full adder: every input combination
    for (int i = 0; i < 8; i++) begin
      iv = i[2:0];
      do_check(0, $sformatf("w1 %0d", i), {15'd0, iv[2]}, {15'd0, iv[1]}, iv[0],
               {15'd0, sum_tab[i]}, cout_tab[i], ovf_tab[i], 2);
    end

    do_check(1, "w8c1 5A+3C", 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0, 1'b1, 9);
    do_check(1, "w8c1 FF+01", 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, 9);
    do_check(1, "w8c1 80+80+1", 16'h80, 16'h80, 1'b1, 16'h01, 1'b1, 1'b1, 9);
    do_check(1, "w8c1 FF+FF+1", 16'hFF, 16'hFF, 1'b1, 16'hFF, 1'b1, 1'b0, 9);
    do_check(2, "w8c4 7F+01", 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1, 3);

    // Start pulsed mid-run must be ignored
    @(negedge clk);
    drive(1, 1'b1, 16'h21, 16'h10, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 16'h00, 16'h00, 1'b0);
    lat2 = 1;
    while (!get_done(1) && lat2 < 64) begin
      if (lat2 == 3) drive(1, 1'b1, 16'hFF, 16'hFF, 1'b1);
      else           drive(1, 1'b0, 16'hFF, 16'hFF, 1'b1);
      @(negedge clk);
      lat2++;
    end
    drive(1, 1'b0, 16'h00, 16'h00, 1'b0);
    check_eq("midrun sum", 32'(get_sum(1)), 32'h31);
    check_eq("midrun cout", 32'(get_cout(1)), 32'(0));
    check_eq("midrun latency", 32'(lat2), 32'(9));
    @(negedge clk);
    check_eq("midrun no restart busy", 32'(get_busy(1)), 32'(0));
    check_eq("midrun no restart done", 32'(get_done(1)), 32'(0));

    // Back-to-back: start held through DONE
    @(negedge clk);
    drive(2, 1'b1, 16'h12, 16'h34, 1'b0);
    lat2 = 0;
    @(negedge clk);
    while (!get_done(2) && lat2 < 64) begin
      @(negedge clk);
      lat2++;
    end
    check_eq("b2b first sum", 32'(get_sum(2)), 32'h46);
    check_eq("b2b first cout", 32'(get_cout(2)), 32'(0));
    drive(2, 1'b1, 16'hF0, 16'h0F, 1'b1);
    @(negedge clk);
    drive(2, 1'b0, 16'h00, 16'h00, 1'b0);
    check_eq("b2b no bubble busy", 32'(get_busy(2)), 32'(1));
    lat2 = 1;
    while (!get_done(2) && lat2 < 64) begin
      @(negedge clk);
      lat2++;
    end
    check_eq("b2b second latency", 32'(lat2), 32'(3));
    check_eq("b2b second sum", 32'(get_sum(2)), 32'h00);
    check_eq("b2b second cout", 32'(get_cout(2)), 32'(1));
    check_eq("b2b second ovf", 32'(get_ovf(2)), 32'(0));

    // Asynchronous reset in the middle of a run
    do_check(1, "pre-reset 5A+3C", 16'h5A, 16'h3C, 1'b0, 16'h96, 1'b0, 1'b1, 9);
    @(negedge clk);
    drive(1, 1'b1, 16'h5A, 16'h3C, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 16'h00, 16'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort busy", 32'(get_busy(1)), 32'(0));
    check_eq("abort done", 32'(get_done(1)), 32'(0));
    check_eq("abort sum",  32'(get_sum(1)),  32'(0));
    check_eq("abort cout", 32'(get_cout(1)), 32'(0));
    check_eq("abort ovf",  32'(get_ovf(1)),  32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (get_done(1) || get_busy(1)) done_seen++;
    end
    check_eq("abort no done pulse", 32'(done_seen), 32'(0));
    do_check(1, "post-reset 3+4", 16'h3, 16'h4, 1'b0, 16'h07, 1'b0, 1'b0, 9);

    // Random sweep on the 16-bit, 2-bit-chunk instance against a+b+cin
    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom_range(0, 65535));
      rb   = 16'($urandom_range(0, 65535));
      rc   = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      do_check(3, $sformatf("rand %0d", i), ra, rb, rc, full[15:0], full[16],
               (ra[15] == rb[15]) && (full[15] != ra[15]), 9);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
